// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters plus registered sync, blank and frame strobes.
// Every strobe is computed from the next counter values, so it lines up with DrawX/DrawY.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_TOTAL   = 800,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_TOTAL   = 525
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       frame_tick,
    output logic [7:0] frame_cnt
);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);

    logic [9:0] h_nxt, v_nxt;
    logic       h_wrap;
    logic       hs_nxt, vs_nxt, blank_nxt, tick_nxt;

    // Wrap compares against the last value, so no counter ever holds H_TOTAL/V_TOTAL.
    always_comb begin
        h_wrap    = (DrawX == H_LAST);
        h_nxt     = h_wrap ? 10'd0 : DrawX + 10'd1;
        v_nxt     = DrawY;
        if (h_wrap)
            v_nxt = (DrawY == V_LAST) ? 10'd0 : DrawY + 10'd1;
        hs_nxt    = !((h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST));
        vs_nxt    = !((v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST));
        blank_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
        tick_nxt  = (h_nxt == 10'd0) && (v_nxt == V_VIS);
    end

    // Reset leaves blank low at (0,0); the first edge after release resumes normal timing.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            DrawX      <= 10'd0;
            DrawY      <= 10'd0;
            hs         <= 1'b1;
            vs         <= 1'b1;
            blank      <= 1'b0;
            frame_tick <= 1'b0;
            frame_cnt  <= 8'd0;
        end else begin
            DrawX      <= h_nxt;
            DrawY      <= v_nxt;
            hs         <= hs_nxt;
            vs         <= vs_nxt;
            blank      <= blank_nxt;
            frame_tick <= tick_nxt;
            if (tick_nxt)
                frame_cnt <= frame_cnt + 8'd1;
        end
    end

endmodule
